// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, buffer state encoding and pointer increment helper
// for the read and write stages of the synchronous power-of-two FIFO.
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_t;

    // Increment modulo 2**width; callers truncate the result to their pointer width.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned width);
        return (ptr + 32'd1) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/rptr_empty.sv
// rptr_empty: read pointer register and pointer-level empty compare.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wptr         write pointer from the write stage
//   inc          advance the read pointer (one read issued)
//   rptr         registered read pointer
//   ptr_empty    rptr == wptr
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wptr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] rptr,
    output logic                  ptr_empty
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rptr <= '0;
        else if (inc)
            rptr <= ADDR_WIDTH'(ptr_next(32'(rptr), ADDR_WIDTH));
    end

    assign ptr_empty = rptr == wptr;

endmodule

// File: rtl/rptr_fwft.sv
// rptr_fwft: FIFO read side with first-word-fall-through two-entry output buffer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wptr                write pointer from the write stage
//   rptr                registered read pointer, fed back to the write stage
//   mem_ren, mem_raddr  storage read strobe and address (address = rptr)
//   mem_rdata           storage read data, valid the cycle after mem_ren
//   m_valid, m_ready    output handshake
//   m_data              registered output word
//   ptr_empty           rptr == wptr
module rptr_fwft
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wptr,
    output logic [ADDR_WIDTH-1:0] rptr,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ptr_empty
);

    buf_state_t state, state_n;
    logic out_v, skid_v, pend, pop, arr, to_out, out_v_n, skid_v_n;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [1:0] occ;

    rptr_empty #(.ADDR_WIDTH(ADDR_WIDTH)) u_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .wptr     (wptr),
        .inc      (mem_ren),
        .rptr     (rptr),
        .ptr_empty(ptr_empty)
    );

    assign out_v     = state != BUF_EMPTY;
    assign skid_v    = state == BUF_TWO;
    assign m_valid   = out_v;
    assign pop       = out_v && m_ready;
    assign arr       = pend;
    assign mem_raddr = rptr;
    assign occ       = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, pend};
    // Occupancy after this cycle's pop must leave room for the word being requested.
    assign mem_ren   = !ptr_empty && (occ - {1'b0, pop}) < 2'd2;
    // An arriving word bypasses skid when the output register is free or being vacated with skid empty.
    assign to_out    = arr && (!out_v || (pop && !skid_v));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= BUF_EMPTY;
        else
            state <= state_n;
    end

    always_comb begin
        out_v_n  = arr || skid_v || (out_v && !pop);
        skid_v_n = (arr && !to_out) || (skid_v && !pop);
        state_n  = skid_v_n ? BUF_TWO : (out_v_n ? BUF_ONE : BUF_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            m_data    <= '0;
            skid_data <= '0;
        end else begin
            pend <= mem_ren;
            if (to_out)
                m_data <= mem_rdata;
            else if (pop && skid_v)
                m_data <= skid_data;
            if (arr && !to_out)
                skid_data <= mem_rdata;
        end
    end

endmodule
